// File: rtl/ps2_rx_kbbuffer.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the PS/2 lines, deserializes 11-bit frames
// and keeps a two-byte scan-code history. Define PS2_TIMEOUT_ERR_EN to flag timeout aborts on Frame_Error.
module ps2_rx_kbbuffer #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] KBBuffer,
    output logic        Code_Ready,
    output logic        Frame_Error,
    output logic        Busy
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
`ifdef PS2_TIMEOUT_ERR_EN
    localparam logic TMO_ERR = 1'b1;
`else
    localparam logic TMO_ERR = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RECV, STOP, CHECK} state_t;
    state_t state, state_next;

    logic [1:0]    clk_sync, data_sync;
    logic          filt_level, fe;
    logic [FW-1:0] filt_cnt;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [8:0]    shift_reg, shift_next;
    logic          stop_bit, stop_next;
    logic [TW-1:0] tmo_cnt, tmo_next;
    logic [15:0]   kb_next;
    logic          code_ready_next, frame_error_next;
    logic          data_bit;

    assign data_bit = data_sync[1];
    assign Busy     = (state != IDLE);

    // Synchronizers preset high so an idle bus produces no edge after reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], PS2_CLK};
            data_sync <= {data_sync[0], PS2_DATA};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fe         <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_sync[1] == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_level <= clk_sync[1];
                filt_cnt   <= '0;
                fe         <= filt_level;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            stop_bit    <= 1'b0;
            tmo_cnt     <= '0;
            KBBuffer    <= 16'h0000;
            Code_Ready  <= 1'b0;
            Frame_Error <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            stop_bit    <= stop_next;
            tmo_cnt     <= tmo_next;
            KBBuffer    <= kb_next;
            Code_Ready  <= code_ready_next;
            Frame_Error <= frame_error_next;
        end
    end

    // Shift register fills LSB-first: after nine bits [7:0] is the byte and [8] the parity
    always_comb begin
        state_next       = state;
        bit_cnt_next     = bit_cnt;
        shift_next       = shift_reg;
        stop_next        = stop_bit;
        tmo_next         = '0;
        kb_next          = KBBuffer;
        code_ready_next  = 1'b0;
        frame_error_next = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_next = '0;
                if (fe && !data_bit) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (fe) begin
                    shift_next   = {data_bit, shift_reg[8:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        state_next = STOP;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next       = IDLE;
                    frame_error_next = TMO_ERR;
                end else begin
                    tmo_next = tmo_cnt + 1'b1;
                end
            end
            STOP: begin
                if (fe) begin
                    stop_next  = data_bit;
                    state_next = CHECK;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_next       = IDLE;
                    frame_error_next = TMO_ERR;
                end else begin
                    tmo_next = tmo_cnt + 1'b1;
                end
            end
            CHECK: begin
                if (stop_bit && (^shift_reg)) begin
                    kb_next         = {KBBuffer[7:0], shift_reg[7:0]};
                    code_ready_next = 1'b1;
                end else begin
                    frame_error_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_rx_kbbuffer.sv
// Self-checking bench for ps2_rx_kbbuffer: directed table, glitch/timeout/reset sequences and random
// frames checked against a queue of accepted bytes.
module tb_ps2_rx_kbbuffer;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DATA = 1'b1;
    logic [15:0] KBBuffer;
    logic        Code_Ready, Frame_Error, Busy;

    int n_vectors = 0;
    int n_miscompares = 0;
    int cr_count = 0;
    int fe_count = 0;
    logic both_seen = 1'b0;
    logic [7:0] accepted[$];

    typedef struct {
        logic [7:0]  data;
        logic        bad_parity;
        logic        stop_val;
        logic [15:0] exp_kb;
        int          exp_cr;
        int          exp_fe;
    } vec_t;

    ps2_rx_kbbuffer #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .CLK(CLK), .RESET(RESET), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .KBBuffer(KBBuffer), .Code_Ready(Code_Ready), .Frame_Error(Frame_Error), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (Code_Ready) cr_count++;
        if (Frame_Error) fe_count++;
        if (Code_Ready && Frame_Error) both_seen = 1'b1;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic bad_par, input logic stop_val);
        logic par;
        par = ~(^b) ^ bad_par;
        return {stop_val, par, b, 1'b0};
    endfunction

    function automatic logic [15:0] modelKb();
        logic [15:0] r;
        r = 16'h0000;
        if (accepted.size() >= 1) r[7:0]  = accepted[accepted.size()-1];
        if (accepted.size() >= 2) r[15:8] = accepted[accepted.size()-2];
        return r;
    endfunction

    // Drives nbits of a frame; glitch mode pulses PS2_CLK low for 1 and FILTER_LEN-1 cycles mid-high-phase
    task automatic sendBits(input logic [10:0] frame, input int nbits, input int half, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = frame[i];
            if (glitch && (i == 3 || i == 6)) begin
                int g;
                g = (i == 3) ? 1 : FILTER_LEN - 1;
                waitCycles(4);
                PS2_CLK = 1'b0;
                waitCycles(g);
                PS2_CLK = 1'b1;
                waitCycles(half - 4 - g);
            end else begin
                waitCycles(half);
            end
            PS2_CLK = 1'b0;
            waitCycles(half);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic applyStimulus(input string name, input vec_t v, input int half, input bit glitch);
        int cr0, fe0;
        cr0 = cr_count;
        fe0 = fe_count;
        sendBits(makeFrame(v.data, v.bad_parity, v.stop_val), 11, half, glitch);
        waitCycles(30);
        checkOutput({name, "_kb"}, KBBuffer, v.exp_kb);
        checkOutput({name, "_code_ready"}, 16'(cr_count - cr0), 16'(v.exp_cr));
        checkOutput({name, "_frame_error"}, 16'(fe_count - fe0), 16'(v.exp_fe));
        checkOutput({name, "_busy"}, {15'd0, Busy}, 16'd0);
    endtask

    initial begin
        vec_t table_v[5];
        vec_t v;
        int fe0, cr0, exp_tmo_fe;

        table_v[0] = '{8'h1C, 1'b0, 1'b1, 16'h001C, 1, 0};
        table_v[1] = '{8'hF0, 1'b0, 1'b1, 16'h1CF0, 1, 0};
        table_v[2] = '{8'h1C, 1'b0, 1'b1, 16'hF01C, 1, 0};
        table_v[3] = '{8'h5A, 1'b1, 1'b1, 16'hF01C, 0, 1};
        table_v[4] = '{8'h5A, 1'b0, 1'b0, 16'hF01C, 0, 1};

        waitCycles(5);
        RESET = 1'b0;
        waitCycles(10);
        checkOutput("reset_kb", KBBuffer, 16'h0000);
        checkOutput("reset_flags", {13'd0, Code_Ready, Frame_Error, Busy}, 16'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("table%0d", i), table_v[i], 20, 1'b0);
            if (table_v[i].exp_cr == 1) accepted.push_back(table_v[i].data);
        end

        // Glitches shorter than the filter length must not produce extra bits
        accepted.push_back(8'h45);
        v = '{8'h45, 1'b0, 1'b1, modelKb(), 1, 0};
        applyStimulus("glitch45", v, 20, 1'b1);

        // Partial frame abandoned by the timeout
        fe0 = fe_count;
        cr0 = cr_count;
        sendBits(makeFrame(8'hAA, 1'b0, 1'b1), 5, 20, 1'b0);
        waitCycles(5);
        checkOutput("timeout_busy_before", {15'd0, Busy}, 16'd1);
        waitCycles(TIMEOUT_CYCLES + 100);
        checkOutput("timeout_busy_after", {15'd0, Busy}, 16'd0);
`ifdef PS2_TIMEOUT_ERR_EN
        exp_tmo_fe = 1;
`else
        exp_tmo_fe = 0;
`endif
        checkOutput("timeout_frame_error", 16'(fe_count - fe0), 16'(exp_tmo_fe));
        checkOutput("timeout_code_ready", 16'(cr_count - cr0), 16'd0);
        accepted.push_back(8'h16);
        v = '{8'h16, 1'b0, 1'b1, modelKb(), 1, 0};
        applyStimulus("after_timeout16", v, 20, 1'b0);

        // Reset in the middle of a frame
        sendBits(makeFrame(8'h05, 1'b0, 1'b1), 6, 20, 1'b0);
        waitCycles(5);
        checkOutput("midframe_busy", {15'd0, Busy}, 16'd1);
        RESET = 1'b1;
        #1;
        checkOutput("reset_busy_now", {15'd0, Busy}, 16'd0);
        checkOutput("reset_kb_now", KBBuffer, 16'h0000);
        waitCycles(3);
        RESET = 1'b0;
        accepted.delete();
        waitCycles(10);
        accepted.push_back(8'h06);
        v = '{8'h06, 1'b0, 1'b1, 16'h0006, 1, 0};
        applyStimulus("after_reset06", v, 20, 1'b0);

        for (int i = 0; i < 16; i++) begin
            logic valid;
            v.data       = 8'($urandom_range(0, 255));
            v.bad_parity = ($urandom_range(0, 4) == 0);
            v.stop_val   = ($urandom_range(0, 7) != 0);
            valid = !v.bad_parity && v.stop_val;
            if (valid) accepted.push_back(v.data);
            v.exp_kb = modelKb();
            v.exp_cr = valid ? 1 : 0;
            v.exp_fe = valid ? 0 : 1;
            applyStimulus($sformatf("rand%0d", i), v, int'($urandom_range(12, 30)), 1'b0);
        end

        checkOutput("no_cr_fe_overlap", {15'd0, both_seen}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
